ukf_output_packer: RTL

Parametrised successor to the UKF result write-back path. Collects 32-bit Cholesky results from N_LANES lower-triangle channels plus one diagonal channel, buffers each channel, and packs elements in round-robin order into BUS_W-bit memory words. Each word carries an incrementing address and per-byte enables. On `finish` it drains all channels, flushes a partial final word, and pulses `done`. It sits between the `ukf` core outputs and the on-chip result RAM, on `clock`.

---
 rtl/ukf_pkg.sv | 25 ++
 rtl/ukf_chan_fifo.sv | 49 ++++
 rtl/ukf_output_packer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ukf_pkg.sv
// Shared types and helpers for the UKF result write-back packer.
package ukf_pkg;

  localparam int ELEM_W_DEF = 32;
  localparam int BE_MAX     = 128;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_EMIT,
    ST_DONE
  } state_e;

  // Sets the low cnt*bytes_per_elem bits; callers truncate to their bus width.
  function automatic logic [BE_MAX-1:0] be_from_count(input int unsigned cnt,
                                                      input int unsigned bytes_per_elem);
    logic [BE_MAX-1:0] be;
    be = '0;
    for (int unsigned i = 0; i < BE_MAX; i++) begin
      if (i < cnt * bytes_per_elem) be[i] = 1'b1;
    end
    return be;
  endfunction

endpackage

// File: rtl/ukf_chan_fifo.sv
// Per-channel synchronous FIFO; the head element is readable without a pop.
module ukf_chan_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
    end
  end

endmodule

// File: rtl/ukf_output_packer.sv
// Buffers lower-triangle and diagonal Cholesky results per channel and packs
// them round-robin into addressed memory words, flushing a partial word on finish.
module ukf_output_packer
  import ukf_pkg::*;
#(
  parameter int N_LANES    = 4,
  parameter int ELEM_W     = ELEM_W_DEF,
  parameter int BUS_W      = 128,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_LANES*ELEM_W-1:0] lower_data,
  input  logic [N_LANES-1:0]        lower_valid,
  input  logic [ELEM_W-1:0]         diag_data,
  input  logic                      diag_valid,
  input  logic                      finish,
  input  logic                      waitrequest,
  output logic [BUS_W-1:0]          write_data,
  output logic [BUS_W/8-1:0]        byteenable,
  output logic [ADDR_W-1:0]         address,
  output logic                      write,
  output logic                      chipselect2,
  output logic                      clken2,
  output logic                      done,
  output logic                      overflow
);

  localparam int NCH   = N_LANES + 1;
  localparam int EPW   = BUS_W / ELEM_W;
  localparam int BE_W  = BUS_W / 8;
  localparam int CNT_W = $clog2(EPW + 1);
  localparam int IDX_W = $clog2(NCH);

  logic [NCH-1:0]    ch_push, ch_pop, ch_full, ch_empty;
  logic [ELEM_W-1:0] ch_din  [NCH];
  logic [ELEM_W-1:0] ch_dout [NCH];

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      if (gi < N_LANES) begin : g_lower
        assign ch_push[gi] = lower_valid[gi];
        assign ch_din[gi]  = lower_data[gi*ELEM_W +: ELEM_W];
      end else begin : g_diag
        assign ch_push[gi] = diag_valid;
        assign ch_din[gi]  = diag_data;
      end
      ukf_chan_fifo #(.WIDTH(ELEM_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (ch_push[gi]),
        .pop   (ch_pop[gi]),
        .din   (ch_din[gi]),
        .dout  (ch_dout[gi]),
        .full  (ch_full[gi]),
        .empty (ch_empty[gi])
      );
    end
  endgenerate

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BUS_W-1:0]  pack_q, pack_d;
  logic              out_valid_q, out_valid_d;
  logic [BUS_W-1:0]  out_data_q, out_data_d;
  logic [BE_W-1:0]   out_be_q, out_be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              overflow_q, overflow_d;

  logic              grant_valid;
  logic [IDX_W-1:0]  grant_idx;
  logic              pop_en;
  logic              accept;
  logic [ELEM_W-1:0] pop_data;

  // Round-robin search starting just after the last served channel.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int off = 1; off <= NCH; off++) begin
      if (!grant_valid && !ch_empty[(int'(last_q) + off) % NCH]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'((int'(last_q) + off) % NCH);
      end
    end
  end

  assign accept   = out_valid_q && !waitrequest;
  assign pop_en   = grant_valid && (state_q == ST_RUN || state_q == ST_FLUSH) &&
                    !(cnt_q == CNT_W'(EPW - 1) && out_valid_q && waitrequest);
  assign pop_data = ch_dout[grant_idx];

  always_comb begin
    ch_pop = '0;
    if (pop_en) ch_pop[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    pack_d      = pack_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_be_d    = out_be_q;
    addr_d      = addr_q;
    overflow_d  = overflow_q | (|(ch_push & ch_full & ~ch_pop));

    if (accept) begin
      out_valid_d = 1'b0;
      addr_d      = addr_q + ADDR_W'(1);
    end

    if (pop_en) begin
      last_d = grant_idx;
      if (cnt_q == CNT_W'(EPW - 1)) begin
        out_data_d = pack_q;
        out_data_d[(EPW-1)*ELEM_W +: ELEM_W] = pop_data;
        out_be_d    = '1;
        out_valid_d = 1'b1;
        cnt_d       = '0;
        pack_d      = '0;
      end else begin
        pack_d[cnt_q*ELEM_W +: ELEM_W] = pop_data;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      ST_RUN: begin
        if (finish) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (&ch_empty && !(|ch_push) && !out_valid_q) state_d = ST_EMIT;
      end
      ST_EMIT: begin
        // The output stage is free on entry, so any word held here is the partial one.
        if (out_valid_q) begin
          if (accept) state_d = ST_DONE;
        end else if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          out_data_d  = pack_q;
          out_be_d    = BE_W'(be_from_count(int'(cnt_q), ELEM_W / 8));
          out_valid_d = 1'b1;
          cnt_d       = '0;
          pack_d      = '0;
        end
      end
      ST_DONE: begin
        addr_d  = ADDR_W'(BASE_ADDR);
        last_d  = IDX_W'(NCH - 1);
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      last_q      <= IDX_W'(NCH - 1);
      cnt_q       <= '0;
      pack_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_be_q    <= '0;
      addr_q      <= ADDR_W'(BASE_ADDR);
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      pack_q      <= pack_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_be_q    <= out_be_d;
      addr_q      <= addr_d;
      overflow_q  <= overflow_d;
    end
  end

  assign write_data  = out_data_q;
  assign byteenable  = out_be_q;
  assign address     = addr_q;
  assign write       = out_valid_q;
  assign chipselect2 = out_valid_q;
  assign clken2      = out_valid_q;
  assign done        = (state_q == ST_DONE);
  assign overflow    = overflow_q;

endmodule
